// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is port A, bit 1 is port B.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    grant_t last_grant_q;
    grant_t last_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Grant depends only on requests and history, never on accept.
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_q == GRANT_B) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i && gnt_o[1]) begin
            last_grant_d = GRANT_B;
        end else if (accept_i && gnt_o[0]) begin
            last_grant_d = GRANT_A;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load unit (B),
// and tracks in-flight destinations in a pending-write scoreboard.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_rd,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_rd,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   write_register,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] busy
);

    logic [1:0]          gnt;
    logic                accept;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;

    logic                reg_write_q,      reg_write_d;
    logic [ADDR_W-1:0]   write_register_q, write_register_d;
    logic [DATA_W-1:0]   write_data_q,     write_data_d;
    logic [NUM_REGS-1:0] busy_q,           busy_d;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({b_valid, a_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign accept  = (a_valid && gnt[0]) || (b_valid && gnt[1]);

    always_comb begin
        sel_rd   = a_rd;
        sel_data = a_data;
        if (gnt[1]) begin
            sel_rd   = b_rd;
            sel_data = b_data;
        end
    end

    // x0 requests are consumed but never reach the register file.
    always_comb begin
        reg_write_d      = accept && (sel_rd != '0);
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (accept) begin
            write_register_d = sel_rd;
            write_data_d     = sel_data;
        end
    end

    // Issue set is applied after the writeback clear so the newer owner wins.
    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            busy_q           <= '0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            busy_q           <= busy_d;
        end
    end

    assign reg_write      = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with immediate-assertion checks.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, issue_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, issue_rd;
    logic [31:0] a_data, b_data;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [31:0] busy;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_write_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_rd           (b_rd),
        .b_data         (b_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ai;
        int bi;
        logic exp_a;

        rst_n = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_write_register", 32'(write_register), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_busy", busy, 32'd0);

        // Single A transfer
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        check("single_a_ready", 32'(a_ready), 32'd1);
        check("single_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        check("single_reg_write", 32'(reg_write), 32'd1);
        check("single_write_register", 32'(write_register), 32'd5);
        check("single_write_data", write_data, 32'hDEADBEEF);
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_reg_write", 32'(reg_write), 32'd0);
        check("idle_hold_register", 32'(write_register), 32'd5);
        check("idle_hold_data", write_data, 32'hDEADBEEF);

        // B write to x0: accepted, not written, leaves last_grant=B
        @(negedge clk);
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
        #1;
        check("x0_b_ready", 32'(b_ready), 32'd1);
        check("x0_a_ready", 32'(a_ready), 32'd0);
        @(posedge clk); #1;
        check("x0_reg_write", 32'(reg_write), 32'd0);
        check("x0_busy", busy, 32'd0);

        // Continuous contention: A,B,A,B with writes 1,10,2,11
        ai = 1; bi = 10; exp_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_valid = 1'b1; a_rd = 5'(ai); a_data = 32'hA000_0000 + 32'(ai);
            b_valid = 1'b1; b_rd = 5'(bi); b_data = 32'hB000_0000 + 32'(bi);
            #1;
            check("rr_a_ready", 32'(a_ready), 32'(exp_a));
            check("rr_b_ready", 32'(b_ready), 32'(!exp_a));
            @(posedge clk); #1;
            check("rr_reg_write", 32'(reg_write), 32'd1);
            if (exp_a) begin
                check("rr_write_register", 32'(write_register), 32'(ai));
                check("rr_write_data", write_data, 32'hA000_0000 + 32'(ai));
                ai++;
            end else begin
                check("rr_write_register", 32'(write_register), 32'(bi));
                check("rr_write_data", write_data, 32'hB000_0000 + 32'(bi));
                bi++;
            end
            exp_a = !exp_a;
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;

        // Scoreboard set, clear, issue to x0, and same-cycle set-wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(posedge clk); #1;
        check("sb_set7", busy, 32'h0000_0080);
        @(negedge clk);
        issue_rd = 5'd0;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7777;
        @(posedge clk); #1;
        check("sb_clear7", busy, 32'h0000_0000);
        check("sb_write7", 32'(write_register), 32'd7);
        @(negedge clk);
        issue_rd = 5'd7;
        a_rd = 5'd7; a_data = 32'h7778;
        #1;
        check("sb_same_a_ready", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        check("sb_set_wins", busy, 32'h0000_0080);
        check("sb_same_reg_write", 32'(reg_write), 32'd1);

        // A held while B wins (last_grant=A), then A accepted
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = '0;
        a_valid = 1'b1; a_rd = 5'd20; a_data = 32'h0A0A;
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h0B0B;
        #1;
        check("hold_a_ready", 32'(a_ready), 32'd0);
        check("hold_b_ready", 32'(b_ready), 32'd1);
        @(posedge clk); #1;
        check("hold_b_written", 32'(write_register), 32'd12);
        check("hold_b_data", write_data, 32'h0B0B);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        check("hold_a_ready2", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        check("hold_a_written", 32'(write_register), 32'd20);
        check("hold_a_data", write_data, 32'h0A0A);
        check("hold_busy", busy, 32'h0000_0080);

        // Issue 3 and 9, accept write to 3, then async reset mid-cycle
        @(negedge clk);
        a_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(posedge clk); #1;
        check("rst_pre_busy3", busy, 32'h0000_0088);
        @(negedge clk);
        issue_rd = 5'd9;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3333;
        @(posedge clk); #1;
        check("rst_pre_busy39", busy, 32'h0000_0280);
        check("rst_pre_reg_write", 32'(reg_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reg_write", 32'(reg_write), 32'd0);
        check("async_busy", busy, 32'd0);
        check("async_write_register", 32'(write_register), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = '0;
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h4444;
        b_valid = 1'b1; b_rd = 5'd14; b_data = 32'hEEEE;
        #1;
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        check("post_rst_write", 32'(write_register), 32'd4);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
